// File: rtl/counter_monitor_pkg.sv
// counter_monitor_pkg: shared types and constants for the counter sequence monitor.
//   state_t    - monitor FSM states (unlocked, locked, fault)
//   ERR_*      - fault class codes reported on ERR_CODE
//   err_class  - maps the two fault conditions onto an ERR_CODE value
package counter_monitor_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SEQ  = 2'b01;
    localparam logic [1:0] ERR_TC   = 2'b10;
    localparam logic [1:0] ERR_BOTH = 2'b11;

    function automatic logic [1:0] err_class(input logic seq_bad, input logic tc_bad);
        if (seq_bad && tc_bad) return ERR_BOTH;
        if (tc_bad)            return ERR_TC;
        if (seq_bad)           return ERR_SEQ;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset (q -> 0)
//   inc - advance by one unless already saturated
//   clr - synchronous clear, wins over inc
//   q   - current count
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    // NOTE: flops are always written with non-blocking assignments so every
    // register in the design updates from pre-edge values, independent of
    // block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/counter_monitor.sv
// counter_monitor: watches a free-running counter's CNT/TC bus, locks onto
// the count sequence, then latches the first skipped/held/reversed count or
// terminal-count mismatch and counts MAX->0 wraps.
//   CLK      - rising-edge clock shared with the observed counter
//   RESET    - asynchronous active-high reset
//   EN       - counter is expected to advance on this edge
//   CLR      - synchronous clear of fault, lock and wrap state (highest priority)
//   CNT      - observed count
//   TC       - observed terminal-count flag
//   LOCKED   - sequence lock acquired (registered)
//   ERR      - sticky fault flag (registered)
//   ERR_CODE - fault class: 01 sequence, 10 TC, 11 both (registered)
//   ERR_VAL  - CNT sampled in the faulting cycle (registered)
//   WRAPS    - saturating count of wraps seen while locked (registered)
module counter_monitor
    import counter_monitor_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int WRAP_WIDTH  = 8,
    parameter int LOCK_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic                  CLR,
    input  logic [WIDTH-1:0]      CNT,
    input  logic                  TC,
    output logic                  LOCKED,
    output logic                  ERR,
    output logic [1:0]            ERR_CODE,
    output logic [WIDTH-1:0]      ERR_VAL,
    output logic [WRAP_WIDTH-1:0] WRAPS
);

    localparam int               LCW         = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCW-1:0]   LOCK_TARGET = LCW'(LOCK_CYCLES);
    localparam logic [WIDTH-1:0] MAX         = '1;

    state_t           state;
    logic [WIDTH-1:0] prev_cnt;
    logic             prev_en;
    logic             have_prev;
    logic [LCW-1:0]   lock_cnt;

    logic [WIDTH-1:0] expected_cnt;
    logic             seq_bad;
    logic             tc_bad;
    logic             wrap_seen;
    logic             wrap_inc;

    // The counter is expected to move by exactly the enable seen on the
    // previous edge; without a previous sample there is nothing to compare.
    assign expected_cnt = prev_cnt + WIDTH'(prev_en);
    assign seq_bad      = have_prev && (CNT != expected_cnt);
    assign tc_bad       = (TC != (CNT == MAX));

    // A wrap only counts on a clean edge while already locked; the edge that
    // drops into FAULT does not contribute.
    assign wrap_seen = have_prev && prev_en && (prev_cnt == MAX) && (CNT == '0);
    assign wrap_inc  = (state == ST_LOCKED) && !CLR && wrap_seen && !seq_bad && !tc_bad;

    sat_counter #(
        .WIDTH(WRAP_WIDTH)
    ) u_wraps (
        .clk (CLK),
        .rst (RESET),
        .inc (wrap_inc),
        .clr (CLR),
        .q   (WRAPS)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_UNLOCKED;
            LOCKED    <= 1'b0;
            ERR       <= 1'b0;
            ERR_CODE  <= ERR_NONE;
            ERR_VAL   <= '0;
            prev_cnt  <= '0;
            prev_en   <= 1'b0;
            have_prev <= 1'b0;
            lock_cnt  <= '0;
        end else if (CLR) begin
            // The sample on a clear edge is discarded entirely.
            state     <= ST_UNLOCKED;
            LOCKED    <= 1'b0;
            ERR       <= 1'b0;
            ERR_CODE  <= ERR_NONE;
            ERR_VAL   <= '0;
            have_prev <= 1'b0;
            lock_cnt  <= '0;
        end else begin
            prev_cnt  <= CNT;
            prev_en   <= EN;
            have_prev <= 1'b1;

            case (state)
                ST_UNLOCKED: begin
                    if (tc_bad) begin
                        state    <= ST_FAULT;
                        LOCKED   <= 1'b0;
                        ERR      <= 1'b1;
                        ERR_CODE <= ERR_TC;
                        ERR_VAL  <= CNT;
                    end else if (have_prev) begin
                        // Sequence mismatches before lock only restart the run.
                        if (seq_bad) begin
                            lock_cnt <= '0;
                        end else if (lock_cnt >= LOCK_TARGET - 1'b1) begin
                            lock_cnt <= LOCK_TARGET;
                            state    <= ST_LOCKED;
                            LOCKED   <= 1'b1;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (seq_bad || tc_bad) begin
                        state    <= ST_FAULT;
                        LOCKED   <= 1'b0;
                        ERR      <= 1'b1;
                        ERR_CODE <= err_class(seq_bad, tc_bad);
                        ERR_VAL  <= CNT;
                    end
                end

                ST_FAULT: begin
                    // Terminal until CLR or RESET; first fault stays recorded.
                end

                default: begin
                    state  <= ST_UNLOCKED;
                    LOCKED <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_monitor.sv
// tb_counter_monitor: directed scenarios plus randomized counter traffic,
// compared every cycle against a behavioural model of the monitor.
module tb_counter_monitor;

    localparam int W   = 4;
    localparam int WW  = 8;
    localparam int LC  = 2;
    localparam int MAXV = 15;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          EN = 1'b0;
    logic          CLR = 1'b0;
    logic [W-1:0]  CNT = '0;
    logic          TC = 1'b0;
    logic          LOCKED;
    logic          ERR;
    logic [1:0]    ERR_CODE;
    logic [W-1:0]  ERR_VAL;
    logic [WW-1:0] WRAPS;

    counter_monitor #(
        .WIDTH(W),
        .WRAP_WIDTH(WW),
        .LOCK_CYCLES(LC)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (EN),
        .CLR      (CLR),
        .CNT      (CNT),
        .TC       (TC),
        .LOCKED   (LOCKED),
        .ERR      (ERR),
        .ERR_CODE (ERR_CODE),
        .ERR_VAL  (ERR_VAL),
        .WRAPS    (WRAPS)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model: "locked" is simply a run of good steps reaching LC,
    // "fault" a latched first error, wraps a clamped integer.
    bit m_locked, m_fault, m_have_prev, m_prev_en;
    int m_prev_cnt, m_run, m_code, m_val, m_wraps;

    task automatic model_reset();
        m_locked = 0; m_fault = 0; m_have_prev = 0; m_prev_en = 0;
        m_prev_cnt = 0; m_run = 0; m_code = 0; m_val = 0; m_wraps = 0;
    endtask

    task automatic model_step(input bit en, input bit clr, input int cnt, input bit tc);
        bit tc_bad, seq_bad;
        if (clr) begin
            m_locked = 0; m_fault = 0; m_code = 0; m_val = 0;
            m_wraps = 0; m_run = 0; m_have_prev = 0;
            return;
        end
        tc_bad  = (tc != (cnt == MAXV));
        seq_bad = m_have_prev && (cnt != (m_prev_cnt + int'(m_prev_en)) % (MAXV + 1));
        if (!m_fault) begin
            if (m_locked) begin
                if (seq_bad || tc_bad) begin
                    m_fault = 1; m_locked = 0; m_val = cnt;
                    m_code = (tc_bad ? 2 : 0) + (seq_bad ? 1 : 0);
                end else if (m_prev_cnt == MAXV && m_prev_en && cnt == 0) begin
                    m_wraps = (m_wraps < 255) ? m_wraps + 1 : 255;
                end
            end else if (tc_bad) begin
                m_fault = 1; m_code = 2; m_val = cnt;
            end else if (m_have_prev) begin
                if (seq_bad) m_run = 0;
                else begin
                    m_run++;
                    if (m_run >= LC) m_locked = 1;
                end
            end
        end
        m_prev_cnt = cnt; m_prev_en = en; m_have_prev = 1;
    endtask

    task automatic compare_all();
        check("locked",   LOCKED,   m_locked);
        check("err",      ERR,      m_fault);
        check("err_code", ERR_CODE, m_code);
        check("err_val",  ERR_VAL,  m_val);
        check("wraps",    WRAPS,    m_wraps);
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next.
    task automatic step(input bit en, input bit clr, input logic [W-1:0] cnt, input bit tc);
        EN = en; CLR = clr; CNT = cnt; TC = tc;
        @(posedge CLK);
        #1;
        model_step(en, clr, int'(cnt), tc);
        compare_all();
    endtask

    logic [W-1:0] dut_cnt = '0;

    task automatic count_step(input bit en);
        step(en, 1'b0, dut_cnt, dut_cnt == W'(MAXV));
        dut_cnt = W'(dut_cnt + W'(en));
    endtask

    task automatic count_to(input logic [W-1:0] target);
        while (dut_cnt != target) count_step(1'b1);
    endtask

    task automatic clr_with_dut_reset();
        step(1'b0, 1'b1, '0, 1'b0);
        dut_cnt = '0;
    endtask

    task automatic relock();
        clr_with_dut_reset();
        check("clr_err",    ERR,    0);
        check("clr_wraps",  WRAPS,  0);
        check("clr_locked", LOCKED, 0);
        repeat (3) count_step(1'b1);
        check("relock", LOCKED, 1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_locked", LOCKED, 0);
        check("rst_err",    ERR, 0);
        check("rst_code",   ERR_CODE, 0);
        check("rst_val",    ERR_VAL, 0);
        check("rst_wraps",  WRAPS, 0);
        RESET = 1'b0;

        // Lock after 0,1,2; sample 3 keeps it.
        repeat (2) count_step(1'b1);
        check("not_locked_yet", LOCKED, 0);
        count_step(1'b1);
        check("locked_3rd", LOCKED, 1);
        count_step(1'b1);

        // 14,15,0,1 -> one wrap.
        count_to(4'd14);
        repeat (4) count_step(1'b1);
        check("wrap_one", WRAPS, 1);
        check("wrap_no_err", ERR, 0);

        // Saturation.
        repeat (300 * 16) count_step(1'b1);
        check("wrap_sat", WRAPS, 255);
        repeat (16) count_step(1'b1);
        check("wrap_sat_hold", WRAPS, 255);

        // Skipped count 5 -> 7.
        count_to(4'd5);
        count_step(1'b1);
        step(1'b1, 1'b0, 4'd7, 1'b0);
        check("skip_err",  ERR, 1);
        check("skip_code", ERR_CODE, 1);
        check("skip_val",  ERR_VAL, 7);
        step(1'b1, 1'b0, 4'd3, 1'b0);
        check("skip_hold_val",  ERR_VAL, 7);
        check("fault_wraps_frozen", WRAPS, 255);

        // TC missing at 15 with correct transition.
        relock();
        count_to(4'd14);
        count_step(1'b1);
        step(1'b1, 1'b0, 4'd15, 1'b0);
        check("tc_code", ERR_CODE, 2);

        // 9 -> 15 with TC=0: both classes.
        relock();
        count_to(4'd9);
        count_step(1'b1);
        step(1'b1, 1'b0, 4'd15, 1'b0);
        check("both_code", ERR_CODE, 3);
        check("both_val",  ERR_VAL, 15);

        // Hold cycles at 6.
        relock();
        count_to(4'd6);
        repeat (4) count_step(1'b0);
        count_step(1'b1);
        count_step(1'b1);
        check("hold_locked", LOCKED, 1);
        check("hold_err",    ERR, 0);

        // One wrap, then asynchronous reset between edges.
        count_to(4'd1);
        check("pre_rst_wraps", WRAPS, 1);
        #3;
        RESET = 1'b1;
        #1;
        check("async_locked", LOCKED, 0);
        check("async_err",    ERR, 0);
        check("async_code",   ERR_CODE, 0);
        check("async_val",    ERR_VAL, 0);
        check("async_wraps",  WRAPS, 0);
        model_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        dut_cnt = '0;

        // Randomized traffic: occasional corrupt samples and clears.
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (m_fault ? (r < 10) : (r < 2)) begin
                clr_with_dut_reset();
            end else if (m_have_prev && r >= 97) begin
                logic [W-1:0] c;
                bit e, t;
                c = W'($urandom_range(0, MAXV));
                e = 1'($urandom_range(0, 1));
                t = 1'($urandom_range(0, 1));
                step(e, 1'b0, c, t);
                dut_cnt = W'(c + W'(e));
            end else begin
                count_step($urandom_range(0, 3) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_monitor.md
# counter_monitor

Self-checking monitor placed directly downstream of the 4-bit `Counter` DUT. It samples the counter's `OUT`/`TC` bus every clock and locks onto the count sequence. Once locked, it flags any skipped, held or reversed count and any terminal-count mismatch. It latches the first fault and counts wrap-arounds, so interactive benches can read a compact pass/fail vector instead of re-deriving the expected sequence.

## Interface
- `WIDTH`, 4, counter width under observation
- `WRAP_WIDTH`, 8, width of the wrap-around counter
- `LOCK_CYCLES`, 2, consecutive good transitions required to lock (≥1)

- `CLK` in 1: rising-edge clock shared with the DUT
- `RESET` in 1: asynchronous, active-high reset
- `EN` in 1: DUT is expected to advance on this edge
- `CLR` in 1: synchronous clear of fault, lock and wrap state
- `CNT` in WIDTH: DUT count output
- `TC` in 1: DUT terminal-count output
- `LOCKED` out 1: sequence lock acquired
- `ERR` out 1: sticky fault flag
- `ERR_CODE` out 2: fault class, where 01 is sequence, 10 is TC, 11 is both
- `ERR_VAL` out WIDTH: `CNT` sampled in the faulting cycle
- `WRAPS` out WRAP_WIDTH: saturating count of MAX→0 wraps seen while locked

## Operation
- `MAX` = 2^WIDTH−1. All arithmetic is modulo 2^WIDTH.
- Each rising edge samples `CNT`, `TC` and `EN` into `prev_cnt`/`prev_en`, and sets `have_prev`.
- Transition check, when `have_prev`=1: good iff `CNT` == `prev_cnt` + `prev_en`.
- TC check, when `have_prev`=1 or 0: good iff `TC` == (`CNT` == `MAX`).
- States:
  - UNLOCKED:
    - TC fault → FAULT.
    - Good transition increments `lock_cnt`. Bad transition clears `lock_cnt` and is not a fault.
    - When `lock_cnt` reaches `LOCK_CYCLES` → LOCKED.
    - The first sample after reset or `CLR` only loads `prev_*`.
  - LOCKED:
    - Bad transition, TC fault, or both → FAULT, with `ERR_CODE` encoding both.
    - `WRAPS` increments when `prev_cnt`=`MAX`, `prev_en`=1 and `CNT`=0. It saturates at all-ones.
  - FAULT:
    - Terminal. `ERR`, `ERR_CODE` and `ERR_VAL` hold.
    - `LOCKED`=0.
    - `WRAPS` freezes.
    - Inputs are still sampled into `prev_*`, but checks are ignored.
- `CLR`=1 at an edge:
  - Next state is UNLOCKED.
  - Clears `ERR`, `ERR_CODE`, `ERR_VAL`, `WRAPS`, `lock_cnt` and `have_prev`.
  - Ignores that cycle's sample, so no fault is raised on it.
  - `CLR` takes priority over every other event.
- Only the first fault is recorded. Later mismatches never overwrite `ERR_CODE`/`ERR_VAL`.

## Timing
- Reset values: state UNLOCKED; `LOCKED`=0, `ERR`=0, `ERR_CODE`=00, `ERR_VAL`=0, `WRAPS`=0, `have_prev`=0, `lock_cnt`=0.
- All outputs are registered.
- A fault sampled at edge k is visible on `ERR` immediately after edge k (one-edge latency). No combinational input→output path exists.
- `LOCKED` rises after the edge that samples the `LOCK_CYCLES`-th consecutive good transition. With defaults, this is the 3rd sample after reset when counting.
- A wrap sampled at edge k shows on `WRAPS` after edge k.
- `RESET` asserted mid-operation clears everything asynchronously. The first edge after release only loads `prev_*`.
- DUT reset to 0 while the monitor is LOCKED is a sequence fault unless `CLR` is asserted in the same cycle. The bench drives `CLR` alongside the DUT `RESET`.
- `EN`=0 hold cycles are legal in every state. `CNT` must be unchanged.

## Structure
- A shared package `counter_monitor_pkg` holds:
  - the state enum (UNLOCKED, LOCKED, FAULT);
  - the `ERR_CODE` constants (`ERR_NONE`=00, `ERR_SEQ`=01, `ERR_TC`=10, `ERR_BOTH`=11).
- One sub-module, `sat_counter` (parameter WIDTH; inputs inc, clr; output q), is used for `WRAPS`. `lock_cnt` is a plain saturating register inline.
- The rest is a single FSM plus sample registers in `counter_monitor`.

## Test plan
- Reset, then `EN`=1 with `CNT` 0,1,2,3 and correct `TC` → `LOCKED`=1 after the 3rd sample, `ERR`=0.
- Locked, count 14,15,0,1 with `TC`=1 only at 15 → `WRAPS`=1, `ERR`=0. Run 300 wraps → `WRAPS`=255 and it holds.
- Locked at 5, then present 7 → `ERR`=1, `ERR_CODE`=01, `ERR_VAL`=7. Next presenting 3 changes nothing.
- Locked, `CNT`=15 with `TC`=0 and the transition correct → `ERR_CODE`=10. On a fresh run, 9→15 with `TC`=0 → `ERR_CODE`=11, `ERR_VAL`=15.
- Locked at 6, `EN`=0 for 4 cycles with `CNT`=6 → no fault. Then `EN`=1 and 7 → still locked.
- In FAULT, pulse `CLR` with DUT `RESET` (`CNT`=0) → `ERR`=0, `WRAPS`=0, UNLOCKED, relocks after 0,1,2. Asserting `RESET` asynchronously mid-count gives all outputs 0 before the next edge.
